// File: rtl/ram_8_fifo_ctrl_if.sv
// Stream and RAM-port signal bundle for ram_8_fifo_ctrl.
// master = the FIFO controller, slave = upstream/downstream/RAM environment.
interface ram_8_fifo_ctrl_if #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 3
);
   logic                 wr_valid;
   logic                 wr_ready;
   logic [WIDTH-1:0]     wr_data;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [WIDTH-1:0]     rd_data;
   logic [ADDR_BITS:0]   count;
   logic [WIDTH-1:0]     ram_in;
   logic [ADDR_BITS-1:0] ram_address;
   logic                 ram_load;
   logic [WIDTH-1:0]     ram_out;

   modport master (
      input  wr_valid, wr_data, rd_ready, ram_out,
      output wr_ready, rd_valid, rd_data, count, ram_in, ram_address, ram_load
   );

   modport slave (
      output wr_valid, wr_data, rd_ready, ram_out,
      input  wr_ready, rd_valid, rd_data, count, ram_in, ram_address, ram_load
   );
endinterface

// File: rtl/ram_8_fifo_ctrl.sv
// Runs a single-port 2**ADDR_BITS x WIDTH RAM (ram_8) as a circular FIFO with a one-word output stage.
// Define RAM_8_FIFO_BYPASS_EN to let a push into an empty FIFO load the output stage directly.
module ram_8_fifo_ctrl #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 3
) (
   input logic               clock,
   input logic               reset,
   ram_8_fifo_ctrl_if.master bus
);

   localparam int unsigned        DEPTH    = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] CNT_FULL = (ADDR_BITS + 1)'(DEPTH);

   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   ram_count_q, ram_count_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0]     rd_data_q, rd_data_d;

   logic                 pop;
   logic                 fetch;
   logic                 bypass;
   logic                 wr_ready;
   logic                 push;
   logic                 ram_load;
   logic [ADDR_BITS-1:0] ram_address;

   // The single RAM port serves either a head fetch or a write each cycle; the fetch has priority.
   always_comb begin
      pop    = rd_valid_q && bus.rd_ready;
      fetch  = (ram_count_q != '0) && (!rd_valid_q || bus.rd_ready);
`ifdef RAM_8_FIFO_BYPASS_EN
      bypass = (ram_count_q == '0) && (!rd_valid_q || bus.rd_ready);
`else
      bypass = 1'b0;
`endif
      wr_ready    = !reset && !fetch && (ram_count_q != CNT_FULL);
      push        = bus.wr_valid && wr_ready;
      ram_load    = push && !bypass;
      ram_address = reset ? '0 : (fetch ? rd_ptr_q : wr_ptr_q);
   end

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through this block infers a latch.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ram_count_d = ram_count_q;
      rd_valid_d  = rd_valid_q;
      rd_data_d   = rd_data_q;

      if (fetch) begin
         rd_data_d   = bus.ram_out;
         rd_valid_d  = 1'b1;
         rd_ptr_d    = rd_ptr_q + 1'b1;
         ram_count_d = ram_count_q - 1'b1;
      end else if (push && bypass) begin
         rd_data_d  = bus.wr_data;
         rd_valid_d = 1'b1;
      end else begin
         if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            ram_count_d = ram_count_q + 1'b1;
         end
         if (pop) begin
            rd_valid_d = 1'b0;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_count_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_count_q <= ram_count_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // RAM contents are never cleared: a location is only fetched after it has been written.
   assign bus.wr_ready    = wr_ready;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.count       = ram_count_q + (ADDR_BITS + 1)'(rd_valid_q);
   assign bus.ram_in      = bus.wr_data;
   assign bus.ram_address = ram_address;
   assign bus.ram_load    = ram_load;

endmodule

// File: tb/tb_ram_8_fifo_ctrl.sv
// Directed and random bench for ram_8_fifo_ctrl with a behavioural 8x16 RAM and a queue scoreboard.
// Expectations follow RAM_8_FIFO_BYPASS_EN when the bench is compiled with it.
module tb_ram_8_fifo_ctrl;
   localparam int WIDTH     = 16;
   localparam int ADDR_BITS = 3;
`ifdef RAM_8_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   pop_total = 0;
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] mem [8];

   ram_8_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

   ram_8_fifo_ctrl #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Behavioural ram_8: synchronous write, combinational read.
   always @(posedge clock) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
   assign bus.ram_out = mem[bus.ram_address];

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard: inputs are stable from posedge+1, so negedge sees what the next edge will transfer.
   always @(negedge clock) begin
      if (!reset) begin
         check(32'(bus.count), 32'(q.size()), "count_model");
         if (bus.rd_valid && bus.rd_ready) begin
            check(32'(q.size() != 0), 32'd1, "pop_underflow");
            if (q.size() != 0) check(32'(bus.rd_data), 32'(q.pop_front()), "pop_order");
            pop_total++;
         end
         if (bus.wr_valid && bus.wr_ready) q.push_back(bus.wr_data);
      end
   end

   task automatic push_word(input logic [WIDTH-1:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      for (int n = 0; n < 32; n++) begin
         #1;
         if (bus.wr_ready) begin
            tick();
            bus.wr_valid = 1'b0;
            return;
         end
         tick();
      end
      check(32'(bus.wr_ready), 32'd1, "push_timeout");
      bus.wr_valid = 1'b0;
   endtask

   task automatic pop_word(input logic [WIDTH-1:0] exp);
      bus.rd_ready = 1'b1;
      for (int n = 0; n < 32; n++) begin
         if (bus.rd_valid) begin
            check(32'(bus.rd_data), 32'(exp), "pop_data");
            tick();
            bus.rd_ready = 1'b0;
            return;
         end
         tick();
      end
      check(32'(bus.rd_valid), 32'd1, "pop_timeout");
      bus.rd_ready = 1'b0;
   endtask

   initial begin
      int start;
      int sent;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;

      // Power-on reset
      #1;
      check(32'(bus.wr_ready), 32'd0, "rst_wr_ready");
      check(32'(bus.ram_load), 32'd0, "rst_ram_load");
      check(32'(bus.ram_address), 32'd0, "rst_ram_address");
      check(32'(bus.count), 32'd0, "rst_count");
      check(32'(bus.rd_valid), 32'd0, "rst_rd_valid");
      repeat (2) tick();
      reset = 1'b0;
      #1;
      check(32'(bus.wr_ready), 32'd1, "post_rst_wr_ready");

      // Single word into an empty FIFO: latency
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'hA5A5;
      #1;
      check(32'(bus.ram_load), 32'(!BYP), "empty_push_ram_load");
      check(32'(bus.ram_address), 32'd0, "empty_push_ram_address");
      tick();
      bus.wr_valid = 1'b0;
      #1;
      check(32'(bus.rd_valid), 32'(BYP), "lat_after_E_rd_valid");
      check(32'(bus.count), 32'd1, "lat_after_E_count");
      check(32'(bus.wr_ready), 32'(BYP), "lat_fetch_wr_ready");
      tick();
      check(32'(bus.rd_valid), 32'd1, "lat_after_E1_rd_valid");
      check(32'(bus.rd_data), 32'hA5A5, "lat_after_E1_rd_data");
      pop_word(16'hA5A5);
      #1;
      check(32'(bus.count), 32'd0, "single_drained_count");
      check(32'(bus.rd_valid), 32'd0, "single_drained_rd_valid");

      // Fill to capacity 9 with rd_ready low, 10th push stalls
      for (int i = 1; i <= 9; i++) push_word(16'(i));
      #1;
      check(32'(bus.count), 32'd9, "full_count");
      check(32'(bus.wr_ready), 32'd0, "full_wr_ready");
      check(32'(bus.rd_data), 32'h0001, "full_head");
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h000A;
      #1;
      check(32'(bus.wr_ready), 32'd0, "full_push_stall");
      check(32'(bus.ram_load), 32'd0, "full_push_no_load");
      tick();
      bus.wr_valid = 1'b0;
      check(32'(bus.count), 32'd9, "full_count_hold");
      for (int i = 1; i <= 9; i++) pop_word(16'(i));
      #1;
      check(32'(bus.count), 32'd0, "full_drained_count");

      // Wrap: 20 words through with rd_ready high
      start = pop_total;
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 20; i++) push_word(16'h1000 + 16'(i));
      for (int n = 0; n < 20 && bus.count != 0; n++) tick();
      bus.rd_ready = 1'b0;
      check(32'(bus.count), 32'd0, "wrap_drained_count");
      check(32'(pop_total - start), 32'd20, "wrap_pop_total");

      // Fetch beats a simultaneous push
      push_word(16'h3001);
      push_word(16'h3002);
      push_word(16'h3003);
      #1;
      check(32'(bus.count), 32'd3, "fetch_pri_count");
      check(32'(bus.rd_valid), 32'd1, "fetch_pri_rd_valid");
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h5555;
      bus.rd_ready = 1'b1;
      #1;
      check(32'(bus.wr_ready), 32'd0, "fetch_pri_wr_ready");
      check(32'(bus.ram_load), 32'd0, "fetch_pri_ram_load");
      tick();
      bus.rd_ready = 1'b0;
      #1;
      check(32'(bus.wr_ready), 32'd1, "fetch_pri_next_wr_ready");
      check(32'(bus.ram_load), 32'd1, "fetch_pri_next_ram_load");
      tick();
      bus.wr_valid = 1'b0;
      check(32'(bus.count), 32'd3, "fetch_pri_after_count");
      pop_word(16'h3002);
      pop_word(16'h3003);
      pop_word(16'h5555);
      #1;
      check(32'(bus.count), 32'd0, "fetch_pri_drained");

      // Reset mid-stream with count 5
      for (int i = 1; i <= 5; i++) push_word(16'h7000 + 16'(i));
      #1;
      check(32'(bus.count), 32'd5, "pre_rst_count");
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h7777;
      reset = 1'b1;
      q.delete();
      #1;
      check(32'(bus.count), 32'd0, "mid_rst_count");
      check(32'(bus.rd_valid), 32'd0, "mid_rst_rd_valid");
      check(32'(bus.wr_ready), 32'd0, "mid_rst_wr_ready");
      check(32'(bus.ram_load), 32'd0, "mid_rst_ram_load");
      tick();
      bus.wr_valid = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      check(32'(bus.wr_ready), 32'd1, "after_rst_wr_ready");
      check(32'(bus.count), 32'd0, "after_rst_count");
      push_word(16'hBEEF);
      pop_word(16'hBEEF);

      // Random valid/ready, 1000 words
      start = pop_total;
      sent  = 0;
      for (int cyc = 0; cyc < 20000 && (pop_total - start) < 1000; cyc++) begin
         bus.wr_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         bus.wr_data  = 16'($urandom);
         bus.rd_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (bus.wr_valid && bus.wr_ready) sent++;
         tick();
      end
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b0;
      #1;
      check(32'(pop_total - start), 32'd1000, "random_pop_total");
      check(32'(bus.count), 32'd0, "random_drained_count");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
